// File: rtl/dt_res_packer_if.sv
// dt_res_packer_if: result-memory read port and output-image write port
// of the distance-map packer.
interface dt_res_packer_if;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        out_wr;
  logic [9:0]  out_addr;
  logic [15:0] out_do;

  modport master (
    output res_rd,
    output res_addr,
    input  res_di,
    output out_wr,
    output out_addr,
    output out_do
  );

  modport slave (
    input  res_rd,
    input  res_addr,
    output res_di,
    input  out_wr,
    input  out_addr,
    input  out_do
  );
endinterface

// File: rtl/dt_res_packer.sv
// dt_res_packer: thresholds the 128x128 DT map into 16-pixel words.
// Optional max distance output enabled by DT_PACK_MAXDIST_EN.
module dt_res_packer #(
  parameter logic [7:0] THRESH    = 8'd1,
  parameter int         IMG_WORDS = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  dt_res_packer_if.master bus,
  output logic            busy,
  output logic            done,
  output logic [14:0]     obj_count
`ifdef DT_PACK_MAXDIST_EN
  ,
  output logic [7:0]      max_dist
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [9:0] LAST =
    10'(IMG_WORDS - 1);

  state_t      state;
  logic [9:0]  word_idx;
  logic [3:0]  pix_idx;
  logic [15:0] sr;
  logic        hit;
  logic [15:0] sr_nx;

  assign hit   = bus.res_di >= THRESH;
  assign sr_nx = {sr[14:0], hit};

  // read data is asynchronous, so the address comes straight off the counters
  assign bus.res_addr = {word_idx, pix_idx};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      word_idx     <= '0;
      pix_idx      <= '0;
      sr           <= '0;
      obj_count    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.res_rd   <= 1'b0;
      bus.out_wr   <= 1'b0;
      bus.out_addr <= '0;
      bus.out_do   <= '0;
`ifdef DT_PACK_MAXDIST_EN
      max_dist     <= '0;
`endif
    end else begin
      unique case (1'b1)
        (state == S_IDLE),
        (state == S_DONE): begin
          if (start) begin
            state      <= S_READ;
            word_idx   <= '0;
            pix_idx    <= '0;
            sr         <= '0;
            obj_count  <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            bus.res_rd <= 1'b1;
            bus.out_wr <= 1'b0;
`ifdef DT_PACK_MAXDIST_EN
            max_dist   <= '0;
`endif
          end
        end
        (state == S_READ): begin
          sr        <= sr_nx;
          obj_count <= obj_count + 15'(hit);
          pix_idx   <= pix_idx + 4'd1;
`ifdef DT_PACK_MAXDIST_EN
          if (bus.res_di > max_dist)
            max_dist <= bus.res_di;
`endif
          if (pix_idx == 4'hF) begin
            state        <= S_WRITE;
            bus.res_rd   <= 1'b0;
            bus.out_wr   <= 1'b1;
            bus.out_addr <= word_idx;
            bus.out_do   <= sr_nx;
          end
        end
        (state == S_WRITE): begin
          bus.out_wr <= 1'b0;
          if (word_idx == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            word_idx   <= word_idx + 10'd1;
            state      <= S_READ;
            bus.res_rd <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dt_res_packer.sv
// tb_dt_res_packer: four packers (two maps x THRESH 1/2) run in lockstep
// against a pixel-level reference model of the packed image.
module tb_dt_res_packer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  logic [7:0]  mem [2][16384];
  logic [3:0]  busy, done, rd, wr;
  logic [13:0] ra  [4];
  logic [9:0]  oa  [4];
  logic [15:0] od  [4];
  logic [14:0] cnt [4];
`ifdef DT_PACK_MAXDIST_EN
  logic [7:0]  mx  [4];
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [25:0] wq [4][$];
  int viol [4];

  for (genvar g = 0; g < 4; g++) begin : L
    dt_res_packer_if b ();
    assign b.res_di = mem[g/2][b.res_addr];
    dt_res_packer #(
      .THRESH   (8'(g % 2 + 1)),
      .IMG_WORDS(1024)
    ) u (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bus      (b),
      .busy     (busy[g]),
      .done     (done[g]),
      .obj_count(cnt[g])
`ifdef DT_PACK_MAXDIST_EN
      ,
      .max_dist (mx[g])
`endif
    );
    assign rd[g] = b.res_rd;
    assign wr[g] = b.out_wr;
    assign ra[g] = b.res_addr;
    assign oa[g] = b.out_addr;
    assign od[g] = b.out_do;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr[i])
        wq[i].push_back({oa[i], od[i]});
      if (wr[i] && rd[i])
        viol[i]++;
    end
  end

  task automatic chk(
    input string      tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_word(
    int m, int w, int th
  );
    logic [15:0] r;
    r = '0;
    for (int p = 0; p < 16; p++)
      if (int'(mem[m][w*16+p]) >= th)
        r[15-p] = 1'b1;
    return r;
  endfunction

  function automatic int ref_cnt(int m, int th);
    int c;
    c = 0;
    for (int k = 0; k < 16384; k++)
      if (int'(mem[m][k]) >= th)
        c++;
    return c;
  endfunction

  function automatic int ref_max(int m);
    int x;
    x = 0;
    for (int k = 0; k < 16384; k++)
      if (int'(mem[m][k]) > x)
        x = int'(mem[m][k]);
    return x;
  endfunction

  task automatic fill(input int m, input int kind);
    for (int k = 0; k < 16384; k++) begin
      case (kind)
        0: mem[m][k] = 8'd0;
        1: mem[m][k] = 8'd5;
        2: mem[m][k] = 8'd0;
        default: mem[m][k] = 8'($urandom_range(0, 3));
      endcase
    end
    if (kind == 2) begin
      mem[m][48] = 8'd1;
      mem[m][63] = 8'd2;
    end
    if (kind == 3) begin
      mem[m][$urandom_range(0, 16383)] = 8'hFF;
      mem[m][$urandom_range(0, 16383)] = 8'h80;
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 4; i++) begin
      wq[i].delete();
      viol[i] = 0;
    end
  endtask

  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("go_busy%0d", i), 64'(busy[i]), 1);
      chk($sformatf("go_rd%0d", i), 64'(rd[i]), 1);
      chk($sformatf("go_addr%0d", i), 64'(ra[i]), 0);
      chk($sformatf("go_cnt%0d", i), 64'(cnt[i]), 0);
    end
  endtask

  task automatic wait_done(
    input int extra,
    output int n
  );
    n = 0;
    while (done !== 4'hF && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == extra);
    end
    start = 1'b0;
  endtask

  task automatic check_pass(input string t);
    int th, m, nbad;
    logic [25:0] e;
    for (int i = 0; i < 4; i++) begin
      th = i % 2 + 1;
      m = i / 2;
      nbad = 0;
      for (int j = 0; j < wq[i].size(); j++) begin
        e = wq[i][j];
        if (e !== {10'(j), ref_word(m, j, th)})
          nbad++;
      end
      chk($sformatf("%s_nwr%0d", t, i),
          64'(wq[i].size()), 1024);
      chk($sformatf("%s_words%0d", t, i), 64'(nbad), 0);
      chk($sformatf("%s_cnt%0d", t, i),
          64'(cnt[i]), 64'(ref_cnt(m, th)));
      chk($sformatf("%s_excl%0d", t, i), 64'(viol[i]), 0);
      chk($sformatf("%s_busy%0d", t, i), 64'(busy[i]), 0);
      chk($sformatf("%s_done%0d", t, i), 64'(done[i]), 1);
`ifdef DT_PACK_MAXDIST_EN
      chk($sformatf("%s_max%0d", t, i),
          64'(mx[i]), 64'(ref_max(m)));
`endif
    end
  endtask

  int n;
  logic [25:0] w;

  initial begin
    fill(0, 0);
    fill(1, 0);
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_busy%0d", i), 64'(busy[i]), 0);
      chk($sformatf("rst_done%0d", i), 64'(done[i]), 0);
      chk($sformatf("rst_rd%0d", i), 64'(rd[i]), 0);
      chk($sformatf("rst_wr%0d", i), 64'(wr[i]), 0);
      chk($sformatf("rst_cnt%0d", i), 64'(cnt[i]), 0);
      chk($sformatf("rst_ra%0d", i), 64'(ra[i]), 0);
      chk($sformatf("rst_oa%0d", i), 64'(oa[i]), 0);
      chk($sformatf("rst_od%0d", i), 64'(od[i]), 0);
    end
    @(negedge clk);
    reset = 1'b1;

    // zero map and all-5 map
    fill(0, 0);
    fill(1, 1);
    clear_log();
    start_pass();
    wait_done(-1, n);
    chk("p1_cycles", 64'(n), 17408);
    check_pass("p1");
    w = (wq[2].size() > 0) ? wq[2][0] : '0;
    chk("p1_ffff", 64'(w[15:0]), 64'hFFFF);
    chk("p1_full", 64'(cnt[2]), 16384);

    // sparse map and random map, stray start mid-pass
    fill(0, 2);
    fill(1, 3);
    clear_log();
    start_pass();
    wait_done(500, n);
    chk("p2_cycles", 64'(n), 17408);
    check_pass("p2");
    w = (wq[0].size() > 3) ? wq[0][3] : '0;
    chk("p2_w3_t1", 64'(w), 64'({10'd3, 16'h8001}));
    w = (wq[1].size() > 3) ? wq[1][3] : '0;
    chk("p2_w3_t2", 64'(w), 64'({10'd3, 16'h0001}));
    chk("p2_cnt_t1", 64'(cnt[0]), 2);
    chk("p2_cnt_t2", 64'(cnt[1]), 1);

    // restart from DONE on fresh random maps
    fill(0, 3);
    fill(1, 3);
    clear_log();
    start_pass();
    wait_done(-1, n);
    chk("p3_cycles", 64'(n), 17408);
    check_pass("p3");

    // reset mid-pass
    fill(1, 1);
    clear_log();
    start_pass();
    repeat (1000) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mr_busy%0d", i), 64'(busy[i]), 0);
      chk($sformatf("mr_done%0d", i), 64'(done[i]), 0);
      chk($sformatf("mr_rd%0d", i), 64'(rd[i]), 0);
      chk($sformatf("mr_wr%0d", i), 64'(wr[i]), 0);
      chk($sformatf("mr_cnt%0d", i), 64'(cnt[i]), 0);
      chk($sformatf("mr_ra%0d", i), 64'(ra[i]), 0);
`ifdef DT_PACK_MAXDIST_EN
      chk($sformatf("mr_max%0d", i), 64'(mx[i]), 0);
`endif
    end
    @(negedge clk);
    reset = 1'b1;
    clear_log();
    repeat (60) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("idle_nwr%0d", i),
          64'(wq[i].size()), 0);
      chk($sformatf("idle_rd%0d", i), 64'(rd[i]), 0);
      chk($sformatf("idle_busy%0d", i), 64'(busy[i]), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
